ledsang_pattern_checker: RTL and testbench

//  Receive-side monitor for the 8-LED fill/drain chaser bus. It samples the LED bus each led_valid posedge
//  (the generator updates on negedge, giving a half-cycle margin) and decodes the position in the 2*WIDTH-step cycle:
//  00,01,03..7F,FF,FE,FC..80,00. Reports level and direction, and flags out-of-sequence patterns.

---
 rtl/ledsang_pattern_checker_pkg.sv | 29 ++
 rtl/ledsang_pattern_checker_if.sv | 34 +++
 rtl/ledsang_pattern_classify.sv | 42 ++++
 rtl/ledsang_pattern_checker.sv | 143 ++++++++++++++
 tb/tb_ledsang_pattern_checker.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ledsang_pattern_checker_pkg.sv
// -----------------------------------------------------------------------------
// ledsang_pkg
// Shared types and helpers for the LED fill/drain chaser checker.
//   LED_W         default LED bus width
//   state_t       tracking state of the checker (HUNT / SYNC / LOCKED)
//   exp_idx()     successor of a cycle index, modulo 2*width
//   idx_to_level()number of lit LEDs for a cycle index
// -----------------------------------------------------------------------------
package ledsang_pkg;

    localparam int unsigned LED_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Index the generator must show next; the cycle has 2*width steps.
    function automatic int unsigned exp_idx(input int unsigned idx, input int unsigned width);
        return (idx + 32'd1) % (32'd2 * width);
    endfunction

    // Fill half counts up to width, drain half counts back down.
    function automatic int unsigned idx_to_level(input int unsigned idx, input int unsigned width);
        return (idx <= width) ? idx : ((32'd2 * width) - idx);
    endfunction

endpackage

// File: rtl/ledsang_pattern_checker_if.sv
// -----------------------------------------------------------------------------
// ledsang_pattern_checker_if
// Bus between the observed chaser and the checker.
//   led_in/led_valid  : observed LED bus and its sample strobe (master -> slave)
//   level/dir/locked  : decoded tracking status (slave -> master)
//   err/wrap          : single-cycle event pulses (slave -> master)
//   err_count         : saturating error count (slave -> master)
// -----------------------------------------------------------------------------
interface ledsang_pattern_checker_if
    import ledsang_pkg::*;
#(
    parameter int unsigned WIDTH = LED_W,
    parameter int unsigned ERR_W = 8,
    parameter int unsigned LVL_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] led_in;
    logic             led_valid;
    logic [LVL_W-1:0] level;
    logic             dir;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_count;

    modport master (
        output led_in, led_valid,
        input  level, dir, locked, err, wrap, err_count
    );

    modport slave (
        input  led_in, led_valid,
        output level, dir, locked, err, wrap, err_count
    );
endinterface

// File: rtl/ledsang_pattern_classify.sv
// -----------------------------------------------------------------------------
// ledsang_pattern_classify
// Combinational decoder of one LED bus sample into its position in the
// fill/drain cycle.
//   i_led    in  WIDTH  LED bus sample
//   o_legal  out 1      sample is a member of the chaser sequence
//   o_idx    out IW     cycle index (0 when illegal)
// Fill patterns (k ones from LSB, k=0..WIDTH) map to idx=k; drain patterns
// (k ones from MSB, k=1..WIDTH-1) map to idx=2*WIDTH-k.
// -----------------------------------------------------------------------------
module ledsang_pattern_classify
    import ledsang_pkg::*;
#(
    parameter int unsigned WIDTH = LED_W,
    parameter int unsigned IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] i_led,
    output logic             o_legal,
    output logic [IW-1:0]    o_idx
);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH:0]   w_fill_hit;
    logic [WIDTH-1:0] w_drain_hit;

    // Match every legal pattern; hits are mutually exclusive so indices can be OR-merged.
    always_comb begin
        w_fill_hit  = '0;
        w_drain_hit = '0;
        o_idx       = '0;
        for (int k = 0; k <= WIDTH; k++) begin
            w_fill_hit[k] = (i_led == ~(ONES << k));
            o_idx         = o_idx | (w_fill_hit[k] ? IW'(k) : {IW{1'b0}});
        end
        // k=WIDTH would be all-ones, already claimed by the fill side as idx=WIDTH.
        for (int k = 1; k < WIDTH; k++) begin
            w_drain_hit[k] = (i_led == (ONES << (WIDTH - k)));
            o_idx          = o_idx | (w_drain_hit[k] ? IW'((2 * WIDTH) - k) : {IW{1'b0}});
        end
        o_legal = (|w_fill_hit) | (|w_drain_hit);
    end
endmodule

// File: rtl/ledsang_pattern_checker.sv
// -----------------------------------------------------------------------------
// ledsang_pattern_checker
// Receive-side monitor for the fill/drain LED chaser. Samples the bus on every
// posedge with led_valid=1, tracks the position in the 2*WIDTH-step cycle and
// reports level/direction, lock status, error and wrap pulses and a
// saturating error count. All outputs are registered (one-cycle latency).
//   clk      in   clock, all flops on posedge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: led_in, led_valid in; level, dir, locked, err,
//            wrap, err_count out
// -----------------------------------------------------------------------------
module ledsang_pattern_checker
    import ledsang_pkg::*;
#(
    parameter int unsigned WIDTH      = LED_W,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ledsang_pattern_checker_if.slave bus
);
    localparam int unsigned    IW       = $clog2(2 * WIDTH);
    localparam int unsigned    LVL_W    = $clog2(WIDTH + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'((2 * WIDTH) - 1);
    localparam logic [IW-1:0]  MID_IDX  = IW'(WIDTH);

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [LVL_W-1:0]   r_level;
    logic               r_dir;
    logic               r_locked;
    logic               r_err;
    logic               r_wrap;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_legal;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_exp;
    logic [LVL_W-1:0]   w_level;
    logic               w_dir;
    logic               w_is_exp;
    logic               w_is_hold;

    ledsang_pattern_classify #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_classify (
        .i_led   (bus.led_in),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    assign w_exp     = IW'(exp_idx(32'(r_idx), WIDTH));
    assign w_level   = LVL_W'(idx_to_level(32'(w_idx), WIDTH));
    assign w_dir     = (w_idx >= MID_IDX);
    assign w_is_exp  = w_legal && (w_idx == w_exp);
    // A repeated sample only counts as a stall when stalls are permitted.
    assign w_is_hold = w_legal && (w_idx == r_idx) && ALLOW_HOLD;

    // Tracking FSM, position registers, event pulses and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HUNT;
            r_idx       <= '0;
            r_level     <= '0;
            r_dir       <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.led_valid) begin
                case (r_state)
                    HUNT: begin
                        // Garbage while hunting is not an error: nothing is tracked yet.
                        if (w_legal) begin
                            r_idx   <= w_idx;
                            r_level <= w_level;
                            r_dir   <= w_dir;
                            r_state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (w_is_exp) begin
                            r_idx    <= w_idx;
                            r_level  <= w_level;
                            r_dir    <= w_dir;
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else if (w_legal) begin
                            // Reloading the same index is identical to holding.
                            r_idx   <= w_idx;
                            r_level <= w_level;
                            r_dir   <= w_dir;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (w_is_exp) begin
                            r_idx   <= w_idx;
                            r_level <= w_level;
                            r_dir   <= w_dir;
                            if (r_idx == LAST_IDX) begin
                                r_wrap <= 1'b1;
                            end
                        end else if (w_is_hold) begin
                            r_state <= LOCKED;
                        end else begin
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            if (r_err_count != {ERR_W{1'b1}}) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                            if (w_legal) begin
                                r_idx   <= w_idx;
                                r_level <= w_level;
                                r_dir   <= w_dir;
                                r_state <= SYNC;
                            end else begin
                                r_state <= HUNT;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.level     = r_level;
    assign bus.dir       = r_dir;
    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
    assign bus.wrap      = r_wrap;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_ledsang_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_ledsang_pattern_checker
// Drives two checkers (stalls allowed / stalls forbidden) with the same LED
// stream and compares both against a behavioural model every cycle, plus
// hand-computed expectations at the directed scenario points.
// -----------------------------------------------------------------------------
module tb_ledsang_pattern_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] led = 8'h00;
    logic       valid = 1'b0;
    bit         chk_en = 1'b0;

    int total = 0;
    int bad   = 0;
    int wraps0 = 0;

    // Model state per DUT: mode 0 = not tracking, 1 = acquiring, 2 = locked.
    int m_mode [2];
    int m_idx  [2];
    int m_level[2];
    int m_cnt  [2];
    bit m_dir  [2];
    bit m_err  [2];
    bit m_wrap [2];
    bit hold_ok[2];

    always #5 clk = ~clk;

    ledsang_pattern_checker_if #(.WIDTH(8), .ERR_W(8)) bus0 ();
    ledsang_pattern_checker_if #(.WIDTH(8), .ERR_W(8)) bus1 ();

    assign bus0.led_in    = led;
    assign bus0.led_valid = valid;
    assign bus1.led_in    = led;
    assign bus1.led_valid = valid;

    ledsang_pattern_checker #(.WIDTH(8), .ERR_W(8), .ALLOW_HOLD(1'b1)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    ledsang_pattern_checker #(.WIDTH(8), .ERR_W(8), .ALLOW_HOLD(1'b0)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position i of the chaser cycle: 00,01,03..FF,FE,FC..80.
    function automatic logic [7:0] pat(input int i);
        int v;
        if (i <= 8) v = (1 << i) - 1;
        else        v = 255 << (i - 8);
        return 8'(v);
    endfunction

    function automatic void classify(input logic [7:0] v, output bit legal, output int idx);
        int n;
        n = $countones(v);
        legal = 1'b0;
        idx = 0;
        if (v == 8'((1 << n) - 1)) begin
            legal = 1'b1;
            idx = n;
        end else if (n >= 1 && n <= 7 && v == 8'(255 << (8 - n))) begin
            legal = 1'b1;
            idx = 16 - n;
        end
    endfunction

    task automatic mclear();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_idx[d] = 0; m_level[d] = 0; m_cnt[d] = 0;
            m_dir[d] = 1'b0; m_err[d] = 1'b0; m_wrap[d] = 1'b0;
        end
    endtask

    task automatic mload(input int d, input int idx);
        m_idx[d]   = idx;
        m_level[d] = (idx <= 8) ? idx : 16 - idx;
        m_dir[d]   = (idx >= 8);
    endtask

    // Advance the model by one clock with the current bus inputs.
    task automatic mstep();
        bit legal;
        int idx;
        int nxt;
        classify(led, legal, idx);
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            m_wrap[d] = 1'b0;
            nxt = (m_idx[d] + 1) % 16;
            if (valid) begin
                if (m_mode[d] == 0) begin
                    if (legal) begin mload(d, idx); m_mode[d] = 1; end
                end else if (m_mode[d] == 1) begin
                    if (!legal) m_mode[d] = 0;
                    else begin
                        if (idx == nxt) m_mode[d] = 2;
                        mload(d, idx);
                    end
                end else begin
                    if (legal && idx == nxt) begin
                        if (m_idx[d] == 15) m_wrap[d] = 1'b1;
                        mload(d, idx);
                    end else if (!(legal && idx == m_idx[d] && hold_ok[d])) begin
                        m_err[d] = 1'b1;
                        if (m_cnt[d] < 255) m_cnt[d]++;
                        if (legal) begin mload(d, idx); m_mode[d] = 1; end
                        else m_mode[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic samp(input logic [7:0] l, input logic v);
        led = l;
        valid = v;
        @(posedge clk);
        mstep();
        @(negedge clk);
    endtask

    function automatic logic [15:0] mexp(input int d);
        return {4'(m_level[d]), m_dir[d], (m_mode[d] == 2), m_err[d], m_wrap[d], 8'(m_cnt[d])};
    endfunction

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("outs0", {bus0.level, bus0.dir, bus0.locked, bus0.err, bus0.wrap, bus0.err_count}, 32'(mexp(0)));
                chk("outs1", {bus1.level, bus1.dir, bus1.locked, bus1.err, bus1.wrap, bus1.err_count}, 32'(mexp(1)));
                if (bus0.wrap) wraps0++;
            end
        end
    end

    initial begin
        int gp;
        int r;
        hold_ok[0] = 1'b1;
        hold_ok[1] = 1'b0;
        mclear();
        repeat (3) @(negedge clk);
        chk("reset_outs0", {bus0.level, bus0.dir, bus0.locked, bus0.err, bus0.wrap, bus0.err_count}, 32'h0);
        chk("reset_outs1", {bus1.level, bus1.dir, bus1.locked, bus1.err, bus1.wrap, bus1.err_count}, 32'h0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Two clean cycles plus the closing 00.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 16; i++) begin
                samp(pat(i), 1'b1);
                if (rep == 0 && i == 0) chk("first_sample_locked", 32'(bus0.locked), 32'd0);
                if (rep == 0 && i == 1) chk("second_sample_locked", 32'(bus0.locked), 32'd1);
                if (rep == 0 && i == 8) chk("full_level", {bus0.level, bus0.dir}, {4'd8, 1'b1});
                if (rep == 1 && i == 0) chk("wrap_after_80", 32'(bus0.wrap), 32'd1);
            end
        end
        samp(8'h00, 1'b1);
        chk("seq_wraps", 32'(wraps0), 32'd2);
        chk("seq_errs", 32'(bus0.err_count), 32'd0);

        // Skip 07 -> 05 (illegal).
        samp(8'h01, 1'b1); samp(8'h03, 1'b1); samp(8'h07, 1'b1);
        samp(8'h05, 1'b1);
        chk("illegal_err", {bus0.err, bus0.locked, bus0.err_count, bus0.level}, {1'b1, 1'b0, 8'd1, 4'd3});
        samp(8'h00, 1'b1); samp(8'h01, 1'b1);
        chk("relock", 32'(bus0.locked), 32'd1);

        // Skip 03 -> 0F (legal but out of order).
        samp(8'h03, 1'b1); samp(8'h0F, 1'b1);
        chk("skip_err", {bus0.err, bus0.locked, bus0.err_count, bus0.level}, {1'b1, 1'b0, 8'd2, 4'd4});
        samp(8'h1F, 1'b1);
        chk("skip_relock", {bus0.err, bus0.locked}, {1'b0, 1'b1});

        // Stall handling.
        samp(8'h3F, 1'b1); samp(8'h3F, 1'b1);
        chk("hold_ok_err", 32'(bus0.err), 32'd0);
        chk("hold_bad_err", {bus1.err, bus1.err_count}, {1'b1, 8'd3});
        samp(8'h3F, 1'b1); samp(8'h7F, 1'b1);
        chk("hold_locked", {bus0.locked, bus1.locked, bus0.err_count}, {1'b1, 1'b1, 8'd2});

        // Idle bus with garbage.
        repeat (10) samp(8'($urandom), 1'b0);
        chk("idle_hold", {bus0.level, bus0.dir, bus0.locked}, {4'd7, 1'b0, 1'b1});
        for (int i = 8; i < 16; i++) samp(pat(i), 1'b1);
        samp(8'h00, 1'b1);
        chk("resume_errs", 32'(bus0.err_count), 32'd2);
        chk("resume_wraps", 32'(wraps0), 32'd3);

        // Randomized traffic: mostly in-order, with stalls, gaps, garbage and jumps.
        gp = 0;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin gp = (gp + 1) % 16; samp(pat(gp), 1'b1); end
            else if (r < 70) samp(pat(gp), 1'b1);
            else if (r < 78) samp(8'($urandom), 1'b0);
            else if (r < 86) samp(8'($urandom), 1'b1);
            else if (r < 92) begin gp = int'($urandom_range(0, 15)); samp(pat(gp), 1'b1); end
            else begin gp = 0; samp(8'h00, 1'b1); end
        end

        // Saturation: every 00,01,05 triple ends in at least one error.
        for (int n = 0; n < 300; n++) begin
            samp(8'h00, 1'b1); samp(8'h01, 1'b1); samp(8'h05, 1'b1);
        end
        chk("sat0", 32'(bus0.err_count), 32'd255);
        chk("sat1", 32'(bus1.err_count), 32'd255);
        samp(8'h00, 1'b0);

        // Asynchronous reset in the middle of the high phase.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        mclear();
        #1;
        chk("async_rst0", {bus0.level, bus0.dir, bus0.locked, bus0.err, bus0.wrap, bus0.err_count}, 32'h0);
        chk("async_rst1", {bus1.level, bus1.dir, bus1.locked, bus1.err, bus1.wrap, bus1.err_count}, 32'h0);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
